scan_unload_ctrl: RTL and testbench
===================================

# scan_unload_ctrl

Scan-chain unload controller: the reading end of a chain of mux-input, clock-enabled flops with select (SD) and enable (SP) inputs. On request it pulses one functional capture (SD=0, SP=1), then drives the chain in shift mode (SD=1) and deserialises the tail output into WORD_W-bit words. Words go out on a valid/ready handshake, and the chain is stalled through SP under back-pressure. It sits between test/debug logic and the chain's SD/SP/D1 pins.

## Interface
- CHAIN_LEN, 16: number of flops in the chain (≥1).
- WORD_W, 8: output word width (1..CHAIN_LEN).
- CK  in  1  clock; all state changes on rising edge.
- SR  in  1  synchronous, active-high reset.
- start  in  1  unload request; sampled only in IDLE.
- scan_fill  in  1  bit driven into chain head (D1 of stage CHAIN_LEN-1) during shift.
- scan_out  in  1  Q of chain tail (stage 0).
- chain_sd  out  1  to all chain SD pins: 0 = functional D0, 1 = shift D1.
- chain_sp  out  1  to all chain SP pins: 1 = load, 0 = hold.
- chain_si  out  1  to head D1; equals scan_fill.
- busy  out  1  high in any state but IDLE.
- out_data  out  WORD_W  assembled word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready at an edge.
- done  out  1  one-cycle pulse at completion.

## Operation
- States: IDLE, CAPTURE, SHIFT, DRAIN.
- IDLE: chain_sd=0, chain_sp=0. start=1 → CAPTURE.
- CAPTURE: one cycle, chain_sd=0, chain_sp=1 (chain loads D0) → SHIFT.
- SHIFT: chain_sd=1; chain_sp = shift_en = !(out_valid & !out_ready) (combinational). On each edge with shift_en: scan_out goes into the assembler at position bit_cnt mod WORD_W; bit_cnt++.
- Bit order: first bit out (stage 0 capture) → bit 0 of word 0; stage k → word k/WORD_W, bit k mod WORD_W.
- When a word fills, or on the last chain bit, it loads into out_data/out_valid on that same edge. Unfilled upper bits of a final partial word are 0.
- After CHAIN_LEN shifts → DRAIN. In DRAIN chain_sp=0; when out_valid clears (or is already clear), assert done for one cycle → IDLE.
- Words per unload = ceil(CHAIN_LEN/WORD_W). bit_cnt width = clog2(CHAIN_LEN+1).
- After completion the chain holds CHAIN_LEN copies of scan_fill.

## Timing
- Reset values: chain_sd=0, chain_sp=0, busy=0, out_valid=0, out_data=0, done=0, state IDLE, bit_cnt=0.
- SR mid-operation aborts immediately; the pending word is discarded and chain contents are left undefined.
- start sampled at edge E0 → CAPTURE during E0..E1; capture happens at E1. With out_ready held 1, bits are sampled at E2..E(1+CHAIN_LEN); first out_valid follows E(1+WORD_W); done is high in the cycle after the last word is accepted.
- Simultaneous accept and new-word load on one edge: out_valid stays 1 with the new data, and there is no bubble.
- out_data is stable while out_valid & !out_ready. Shifting stops in that condition, so no bit is lost or duplicated.
- start while busy is ignored. start in the same cycle as done is ignored; it is honoured from the next cycle.

## Structure
- Shared package scan_pkg: state enum (IDLE/CAPTURE/SHIFT/DRAIN), SD encodings (SD_FUNC=0, SD_SHIFT=1), bit-order constant.
- Sub-module scan_word_pack: bit-serial-to-word assembler with output register and valid/ready; the controller FSM and bit counter stay in scan_unload_ctrl.

## Test plan
- Bench model: 16 mux/enable flops, stage 0 = tail.
- CHAIN_LEN=16, WORD_W=8, D0=0xA5C3, out_ready=1 → words 0xC3 then 0xA5; done follows the last accept, 18+ cycles after start.
- Same case with out_ready low for 5 cycles while the first word is pending → chain_sp=0 during the stall; words are still exactly 0xC3, 0xA5.
- CHAIN_LEN=12, WORD_W=8, D0=0xABC → words 0xBC, 0x0A.
- SR=1 at the 6th shift cycle → next cycle all outputs are at reset values. A new start then completes a full correct unload of a re-captured 0x1234 → 0x34, 0x12.
- start pulsed during SHIFT and on the done cycle → ignored; exactly one set of words per accepted start.
- scan_fill=1 unload, then a second unload with D0 driven to chain Q (capture hold) → words 0xFF, 0xFF.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM states, chain select encodings and unload bit order.
package scan_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DRAIN   = 2'd3
    } state_e;
    localparam logic SD_FUNC  = 1'b0;
    localparam logic SD_SHIFT = 1'b1;
    // First bit out of the chain lands in bit 0 of the word.
    localparam bit LSB_FIRST = 1'b1;
endpackage

// File: rtl/scan_word_pack.sv
// scan_word_pack: bit-serial to word assembler with registered valid/ready output.
module scan_word_pack
    import scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int PW     = WORD_W > 1 ? $clog2(WORD_W) : 1
) (
    input  logic              CK,
    input  logic              SR,
    input  logic              push_i,
    input  logic              bit_i,
    input  logic [PW-1:0]     pos_i,
    input  logic              last_i,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_valid_o
);
    logic [WORD_W-1:0] acc_q, acc_d, data_q;
    logic              valid_q, load;

    always_comb begin
        acc_d = acc_q;
        acc_d[LSB_FIRST ? pos_i : PW'(WORD_W - 1) - pos_i] = bit_i;
        load = push_i && (last_i || pos_i == PW'(WORD_W - 1));
    end

    // Accumulator clears on each load so a short final word has zero upper bits.
    always_ff @(posedge CK) begin
        if (SR) begin
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            acc_q   <= '0;
            data_q  <= acc_d;
            valid_q <= 1'b1;
        end else begin
            if (push_i) acc_q <= acc_d;
            if (out_ready_i) valid_q <= 1'b0;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
endmodule

// File: rtl/scan_unload_ctrl.sv
// scan_unload_ctrl: captures a scan chain, shifts it out and delivers it as words.
module scan_unload_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic              CK,
    input  logic              SR,
    input  logic              start,
    input  logic              scan_fill,
    input  logic              scan_out,
    output logic              chain_sd,
    output logic              chain_sp,
    output logic              chain_si,
    output logic              busy,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int PW = WORD_W > 1 ? $clog2(WORD_W) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pos;
    logic            shift_en, push, last;

    assign shift_en = !(out_valid && !out_ready);
    assign done     = state_q == DRAIN && !out_valid;

    always_comb begin
        push    = state_q == SHIFT && shift_en;
        last    = cnt_q == CW'(CHAIN_LEN - 1);
        pos     = PW'(cnt_q % CW'(WORD_W));
        cnt_d   = push ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
        state_d = (state_q == IDLE && start) ? CAPTURE :
                  (state_q == CAPTURE)       ? SHIFT   :
                  (push && last)             ? DRAIN   :
                  done                       ? IDLE    : state_q;
    end

    always_ff @(posedge CK) begin
        if (SR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The chain is stalled through SP whenever a word is waiting on the consumer.
    assign chain_sd = state_q == SHIFT ? SD_SHIFT : SD_FUNC;
    assign chain_sp = state_q == CAPTURE || push;
    assign chain_si = scan_fill;
    assign busy     = state_q != IDLE;

    scan_word_pack #(.WORD_W(WORD_W)) u_pack (
        .CK         (CK),
        .SR         (SR),
        .push_i     (push),
        .bit_i      (scan_out),
        .pos_i      (pos),
        .last_i     (last),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid)
    );
endmodule

// File: tb/tb_scan_unload_ctrl.sv
// tb_scan_unload_ctrl: scoreboard bench driving 16- and 12-flop chain models.
module tb_scan_unload_ctrl;
    logic CK = 1'b0;
    logic SR = 1'b1;
    always #5 CK = ~CK;

    int errors = 0;
    int checks = 0;

    logic        start_a = 0, fill_a = 0, ready_a = 1, hold_a = 0;
    logic [15:0] d0_a = '0;
    bit   [15:0] chain_a = '0;
    logic        sd_a, sp_a, si_a, busy_a, valid_a, done_a;
    logic [7:0]  data_a;

    logic        start_b = 0, ready_b = 1;
    logic [11:0] d0_b = '0;
    bit   [11:0] chain_b = '0;
    logic        sd_b, sp_b, si_b, busy_b, valid_b, done_b;
    logic [7:0]  data_b;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    scan_unload_ctrl #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
        .CK(CK), .SR(SR), .start(start_a), .scan_fill(fill_a), .scan_out(chain_a[0]),
        .chain_sd(sd_a), .chain_sp(sp_a), .chain_si(si_a), .busy(busy_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .done(done_a)
    );

    scan_unload_ctrl #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .CK(CK), .SR(SR), .start(start_b), .scan_fill(1'b0), .scan_out(chain_b[0]),
        .chain_sd(sd_b), .chain_sp(sp_b), .chain_si(si_b), .busy(busy_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .done(done_b)
    );

    // Mux/enable flop chains, stage 0 is the tail.
    always @(posedge CK) if (sp_a) chain_a <= sd_a ? {si_a, chain_a[15:1]} : (hold_a ? chain_a : d0_a);
    always @(posedge CK) if (sp_b) chain_b <= sd_b ? {si_b, chain_b[11:1]} : d0_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] word(input logic [15:0] d0, input int len, input int k);
        logic [15:0] v;
        int n;
        v = d0 >> (8 * k);
        n = len - 8 * k;
        if (n < 8) v = v & ((16'd1 << n) - 16'd1);
        return v[7:0];
    endfunction

    always @(negedge CK) begin
        if (!SR && valid_a && ready_a) begin
            check("a_word_expected", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) check("a_word", data_a, qa.pop_front());
        end
        if (!SR && valid_b && ready_b) begin
            check("b_word_expected", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) check("b_word", data_b, qb.pop_front());
        end
    end

    task automatic run_a(input logic [15:0] d0, input bit fill, input bit hold, input bit stall, input bit noisy);
        int n;
        d0_a = d0; fill_a = fill; hold_a = hold; ready_a = 1;
        for (int k = 0; k < 2; k++) qa.push_back(word(d0, 16, k));
        start_a = 1;
        @(posedge CK); #1 start_a = 0;
        n = 0;
        while (n < 80) begin
            @(negedge CK);
            if (done_a) break;
            if (n == 8) check("a_valid_early", valid_a, 0);
            if (n == 9) check("a_first_valid", valid_a, 1);
            if (stall && n >= 9 && n <= 13) begin
                check("a_stall_sp", sp_a, 0);
                check("a_stall_data", data_a, word(d0, 16, 0));
            end
            @(posedge CK); n++; #1;
            if (stall) ready_a = !(n >= 9 && n <= 13);
            if (noisy) start_a = (n == 5 || n == 18);
        end
        check("a_done_lat", n, stall ? 23 : 18);
        @(posedge CK); #1 start_a = 0; ready_a = 1;
        repeat (3) begin
            @(negedge CK);
            check("a_done_pulse", done_a, 0);
            check("a_idle_busy", busy_a, 0);
        end
        check("a_sb_empty", qa.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge CK);
        @(negedge CK);
        check("rst_sd", sd_a, 0);
        check("rst_sp", sp_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_done", done_a, 0);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_valid", valid_b, 0);
        @(posedge CK); #1 SR = 0;

        run_a(16'hA5C3, 0, 0, 0, 0);
        run_a(16'hA5C3, 0, 0, 1, 0);

        d0_b = 12'hABC;
        qb.push_back(8'hBC); qb.push_back(8'h0A);
        start_b = 1;
        @(posedge CK); #1 start_b = 0;
        n = 0;
        while (n < 80) begin
            @(negedge CK);
            if (done_b) break;
            @(posedge CK); n++; #1;
        end
        check("b_done_lat", n, 14);
        check("b_sb_empty", qb.size(), 0);

        d0_a = 16'h5A5A;
        for (int k = 0; k < 2; k++) qa.push_back(word(16'h5A5A, 16, k));
        start_a = 1;
        @(posedge CK); #1 start_a = 0;
        repeat (6) @(posedge CK);
        #1;
        check("abort_in_shift", sd_a, 1);
        SR = 1;
        @(posedge CK); #1 SR = 0;
        qa.delete();
        @(negedge CK);
        check("abort_sd", sd_a, 0);
        check("abort_sp", sp_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_valid", valid_a, 0);
        check("abort_data", data_a, 0);
        check("abort_done", done_a, 0);
        run_a(16'h1234, 0, 0, 0, 0);

        run_a(16'h3C96, 0, 0, 0, 1);

        run_a(16'h0F0F, 1, 0, 0, 0);
        check("chain_filled", chain_a, 16'hFFFF);
        run_a(16'hFFFF, 0, 1, 0, 0);

        repeat (2) @(posedge CK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
